cu_mc: RTL and testbench

- Multi-cycle, parametrised successor to the combinational opcode decoder.
- Sequences each instruction through fetch / decode / execute / memory / writeback states and drives the same datapath control set: register file, ALU, writeback mux.
- Adds an instruction handshake, a memory handshake with timeout, a carry flag for ADC, a register-clear sequence after reset, and a halt state.
- Sits between the instruction source and the datapath.

---
 rtl/cu_pkg.sv | 35 +++
 rtl/cu_mc_if.sv | 47 ++++
 rtl/cu_decode.sv | 52 +++++
 rtl/cu_mc.sv | 173 +++++++++++++++++
 tb/tb_cu_mc.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// opcode classes and the inst_type / wb_sel codes driven to the datapath.
package cu_pkg;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_ADD   = 6'b000001;
  localparam logic [5:0] OP_SUB   = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b000011;
  localparam logic [5:0] OP_OR    = 6'b000100;
  localparam logic [5:0] OP_XOR   = 6'b000101;
  localparam logic [5:0] OP_ADC   = 6'b000110;
  localparam logic [5:0] OP_LDIM  = 6'b001110;
  localparam logic [5:0] OP_LOAD  = 6'b010000;
  localparam logic [5:0] OP_STORE = 6'b010001;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    ST_INIT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_LDIM, CLS_LOAD, CLS_STORE, CLS_HLT, CLS_ILL
  } op_class_t;

  localparam logic [1:0] IT_NONE = 2'b00;
  localparam logic [1:0] IT_R    = 2'b01;
  localparam logic [1:0] IT_I    = 2'b10;
  localparam logic [1:0] IT_M    = 2'b11;

  localparam logic [2:0] WB_NONE = 3'b000;
  localparam logic [2:0] WB_IMM  = 3'b001;
  localparam logic [2:0] WB_ALU  = 3'b010;
  localparam logic [2:0] WB_MEM  = 3'b011;

endpackage

// File: rtl/cu_mc_if.sv
// Bundle between the instruction source / datapath (master) and the control unit (slave).
// An opcode is accepted on a cycle where instr_valid and instr_ready are both high;
// a memory access completes on the first cycle mem_ack is high while mem_req is high.
interface cu_mc_if #(
  parameter int OPCODE_W  = 6,
  parameter int ALU_SEL_W = 4,
  parameter int WB_SEL_W  = 3
);
  import cu_pkg::*;

  logic                 instr_valid;
  logic [OPCODE_W-1:0]  opcode;
  logic                 instr_ready;
  logic                 alu_carry_out;
  logic                 mem_ack;
  logic                 mem_req;
  logic                 mem_we;
  logic                 alu_c_in;
  logic                 alu_enable;
  logic [ALU_SEL_W-1:0] alu_sel;
  logic                 reg_read_a;
  logic                 reg_read_b;
  logic                 reg_write;
  logic                 reg_reset;
  logic [1:0]           inst_type;
  logic [WB_SEL_W-1:0]  wb_sel;
  logic                 pc_inc;
  logic                 halted;
  logic                 illegal_op;
  logic                 bus_error;
  state_t               state_dbg;

  modport slave (
    input  instr_valid, opcode, alu_carry_out, mem_ack,
    output instr_ready, mem_req, mem_we, alu_c_in, alu_enable, alu_sel,
           reg_read_a, reg_read_b, reg_write, reg_reset, inst_type, wb_sel,
           pc_inc, halted, illegal_op, bus_error, state_dbg
  );

  modport master (
    output instr_valid, opcode, alu_carry_out, mem_ack,
    input  instr_ready, mem_req, mem_we, alu_c_in, alu_enable, alu_sel,
           reg_read_a, reg_read_b, reg_write, reg_reset, inst_type, wb_sel,
           pc_inc, halted, illegal_op, bus_error, state_dbg
  );

endinterface

// File: rtl/cu_decode.sv
// Combinational opcode classifier: legality, class, ALU function, writeback
// source and instruction type for the latched opcode.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int ALU_SEL_W = 4,
  parameter int WB_SEL_W  = 3
) (
  input  logic [OPCODE_W-1:0]  opcode,
  output logic                 legal,
  output op_class_t            op_class,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic [WB_SEL_W-1:0]  wb_sel,
  output logic [1:0]           inst_type
);

  always_comb begin
    legal     = 1'b1;
    op_class  = CLS_ILL;
    alu_sel   = '0;
    wb_sel    = WB_SEL_W'(WB_NONE);
    inst_type = IT_NONE;
    case (opcode)
      OPCODE_W'(OP_NOP): op_class = CLS_NOP;
      OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_AND),
      OPCODE_W'(OP_OR),  OPCODE_W'(OP_XOR), OPCODE_W'(OP_ADC): begin
        op_class  = CLS_ALU;
        alu_sel   = ALU_SEL_W'(opcode[3:0]);
        wb_sel    = WB_SEL_W'(WB_ALU);
        inst_type = IT_R;
      end
      OPCODE_W'(OP_LDIM): begin
        op_class  = CLS_LDIM;
        wb_sel    = WB_SEL_W'(WB_IMM);
        inst_type = IT_I;
      end
      OPCODE_W'(OP_LOAD): begin
        op_class  = CLS_LOAD;
        wb_sel    = WB_SEL_W'(WB_MEM);
        inst_type = IT_M;
      end
      OPCODE_W'(OP_STORE): begin
        op_class  = CLS_STORE;
        inst_type = IT_M;
      end
      OPCODE_W'(OP_HLT): op_class = CLS_HLT;
      default:           legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/cu_mc.sv
// Multi-cycle control unit: INIT/FETCH/DECODE/EXEC/MEM/WB/HALT sequencer that
// drives register file, ALU and writeback-mux controls from state and opcode_q.
module cu_mc
  import cu_pkg::*;
#(
  parameter int OPCODE_W       = 6,
  parameter int ALU_SEL_W      = 4,
  parameter int WB_SEL_W       = 3,
  parameter int REG_CLR_CYCLES = 1,
  parameter int MEM_TIMEOUT    = 15
) (
  input logic    clk,
  input logic    rst,
  cu_mc_if.slave bus
);

  localparam int CLR_W  = (REG_CLR_CYCLES < 2) ? 1 : $clog2(REG_CLR_CYCLES);
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(REG_CLR_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit                TO_EN     = (MEM_TIMEOUT != 0);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic                carry_q, carry_d;
  logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                 dec_legal;
  op_class_t            dec_class;
  logic [ALU_SEL_W-1:0] dec_alu_sel;
  logic [WB_SEL_W-1:0]  dec_wb_sel;
  logic [1:0]           dec_inst_type;

  cu_decode #(
    .OPCODE_W (OPCODE_W),
    .ALU_SEL_W(ALU_SEL_W),
    .WB_SEL_W (WB_SEL_W)
  ) u_decode (
    .opcode   (opcode_q),
    .legal    (dec_legal),
    .op_class (dec_class),
    .alu_sel  (dec_alu_sel),
    .wb_sel   (dec_wb_sel),
    .inst_type(dec_inst_type)
  );

  logic is_alu, is_store, mem_timeout;
  assign is_alu      = (dec_class == CLS_ALU);
  assign is_store    = (dec_class == CLS_STORE);
  // Ack in the final wait cycle still completes the access normally.
  assign mem_timeout = TO_EN && (wait_q == WAIT_LAST) && !bus.mem_ack;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    carry_d   = carry_q;
    clr_cnt_d = clr_cnt_q;
    wait_d    = wait_q;
    case (state_q)
      ST_INIT: begin
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = ST_FETCH;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      ST_FETCH: begin
        if (bus.instr_valid) begin
          opcode_d = bus.opcode;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_class == CLS_HLT)                     state_d = ST_HALT;
        else if (!dec_legal || dec_class == CLS_NOP) state_d = ST_FETCH;
        else                                          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_alu) carry_d = bus.alu_carry_out;
        state_d = (dec_class == CLS_LOAD || is_store) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          wait_d  = '0;
          state_d = is_store ? ST_FETCH : ST_WB;
        end else if (mem_timeout) begin
          wait_d  = '0;
          state_d = ST_FETCH;
        end else if (TO_EN) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      opcode_q  <= OPCODE_W'(OP_NOP);
      carry_q   <= 1'b0;
      clr_cnt_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      carry_q   <= carry_d;
      clr_cnt_q <= clr_cnt_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    bus.instr_ready = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.alu_c_in    = 1'b0;
    bus.alu_enable  = 1'b0;
    bus.alu_sel     = '0;
    bus.reg_read_a  = 1'b0;
    bus.reg_read_b  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.reg_reset   = 1'b0;
    bus.inst_type   = IT_NONE;
    bus.wb_sel      = '0;
    bus.pc_inc      = 1'b0;
    bus.halted      = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.bus_error   = 1'b0;
    bus.state_dbg   = state_q;
    case (state_q)
      ST_INIT:  bus.reg_reset   = 1'b1;
      ST_FETCH: bus.instr_ready = 1'b1;
      ST_DECODE: begin
        bus.illegal_op = !dec_legal;
        bus.pc_inc     = !dec_legal || (dec_class == CLS_NOP);
      end
      ST_EXEC: begin
        if (is_alu) begin
          bus.alu_enable = 1'b1;
          bus.reg_read_a = 1'b1;
          bus.reg_read_b = 1'b1;
          bus.inst_type  = dec_inst_type;
          bus.alu_sel    = dec_alu_sel;
          if (opcode_q == OPCODE_W'(OP_SUB))      bus.alu_c_in = 1'b1;
          else if (opcode_q == OPCODE_W'(OP_ADC)) bus.alu_c_in = carry_q;
        end
      end
      ST_MEM: begin
        bus.mem_req    = 1'b1;
        bus.inst_type  = IT_M;
        bus.reg_read_a = 1'b1;
        bus.mem_we     = is_store;
        bus.reg_read_b = is_store;
        bus.bus_error  = mem_timeout;
        bus.pc_inc     = mem_timeout || (is_store && bus.mem_ack);
      end
      ST_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_inc    = 1'b1;
        bus.wb_sel    = dec_wb_sel;
        if (dec_class == CLS_LDIM) bus.inst_type = dec_inst_type;
      end
      ST_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cu_mc.sv
// Directed bench for cu_mc: the driver pushes the hand-computed output vector
// for every cycle it drives; a negedge monitor pops and compares.
module tb_cu_mc;
  import cu_pkg::*;

  localparam int W = 22;
  localparam logic [W-1:0] V_IR  = 22'h1 << 21;
  localparam logic [W-1:0] V_MRQ = 22'h1 << 20;
  localparam logic [W-1:0] V_MWE = 22'h1 << 19;
  localparam logic [W-1:0] V_CIN = 22'h1 << 18;
  localparam logic [W-1:0] V_AEN = 22'h1 << 17;
  localparam logic [W-1:0] V_RA  = 22'h1 << 12;
  localparam logic [W-1:0] V_RB  = 22'h1 << 11;
  localparam logic [W-1:0] V_RW  = 22'h1 << 10;
  localparam logic [W-1:0] V_RR  = 22'h1 << 9;
  localparam logic [W-1:0] V_PC  = 22'h1 << 3;
  localparam logic [W-1:0] V_H   = 22'h1 << 2;
  localparam logic [W-1:0] V_ILL = 22'h1 << 1;
  localparam logic [W-1:0] V_BE  = 22'h1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  cu_mc_if #(.OPCODE_W(6), .ALU_SEL_W(4), .WB_SEL_W(3)) bus ();

  cu_mc #(
    .OPCODE_W(6), .ALU_SEL_W(4), .WB_SEL_W(3),
    .REG_CLR_CYCLES(3), .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] f_sel(input logic [3:0] s);
    return W'(s) << 13;
  endfunction
  function automatic logic [W-1:0] f_it(input logic [1:0] t);
    return W'(t) << 7;
  endfunction
  function automatic logic [W-1:0] f_wb(input logic [2:0] w);
    return W'(w) << 4;
  endfunction

  // Vectors for the recurring cycles of each instruction class.
  function automatic logic [W-1:0] v_exec(input logic [3:0] s, input logic cin);
    return V_AEN | V_RA | V_RB | f_it(2'b01) | f_sel(s) | (cin ? V_CIN : '0);
  endfunction
  localparam logic [W-1:0] V_ALU_WB = V_RW | V_PC | (22'h2 << 4);
  localparam logic [W-1:0] V_LD_MEM = V_MRQ | V_RA | (22'h3 << 7);
  localparam logic [W-1:0] V_ST_MEM = V_MRQ | V_MWE | V_RA | V_RB | (22'h3 << 7);

  task automatic cyc(input logic [W-1:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [5:0] op, input string nm);
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    cyc(V_IR, nm);
    bus.instr_valid = 1'b0;
    bus.opcode      = 6'b0;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] act, e;
    string        n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      act = {bus.instr_ready, bus.mem_req, bus.mem_we, bus.alu_c_in, bus.alu_enable,
             bus.alu_sel, bus.reg_read_a, bus.reg_read_b, bus.reg_write, bus.reg_reset,
             bus.inst_type, bus.wb_sel, bus.pc_inc, bus.halted, bus.illegal_op,
             bus.bus_error};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: outputs got=%06h expected=%06h", n, act, e);
      end
    end
  end

  initial begin
    bus.instr_valid   = 1'b0;
    bus.opcode        = 6'b0;
    bus.alu_carry_out = 1'b0;
    bus.mem_ack       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Register clear: exactly three cycles, then FETCH.
    for (int i = 0; i < 3; i++) cyc(V_RR, "init_clear");

    // LDIM: ready again four cycles after accept.
    fetch(OP_LDIM, "ldim_fetch");
    cyc('0, "ldim_decode");
    cyc('0, "ldim_exec");
    cyc(V_RW | V_PC | f_it(2'b10) | f_wb(3'b001), "ldim_wb");

    // ADD sets carry, ADC consumes it, SUB forces carry-in, ADC sees cleared carry.
    fetch(OP_ADD, "add_fetch");
    cyc('0, "add_decode");
    bus.alu_carry_out = 1'b1;
    cyc(v_exec(4'b0001, 1'b0), "add_exec");
    bus.alu_carry_out = 1'b0;
    cyc(V_ALU_WB, "add_wb");
    fetch(OP_ADC, "adc_fetch");
    cyc('0, "adc_decode");
    cyc(v_exec(4'b0110, 1'b1), "adc_exec_cin1");
    cyc(V_ALU_WB, "adc_wb");
    fetch(OP_SUB, "sub_fetch");
    cyc('0, "sub_decode");
    cyc(v_exec(4'b0010, 1'b1), "sub_exec");
    cyc(V_ALU_WB, "sub_wb");
    fetch(OP_ADC, "adc2_fetch");
    cyc('0, "adc2_decode");
    cyc(v_exec(4'b0110, 1'b0), "adc2_exec_cin0");
    cyc(V_ALU_WB, "adc2_wb");
    fetch(OP_XOR, "xor_fetch");
    cyc('0, "xor_decode");
    cyc(v_exec(4'b0101, 1'b0), "xor_exec");
    cyc(V_ALU_WB, "xor_wb");

    // LOAD acked on the third MEM cycle.
    fetch(OP_LOAD, "load_fetch");
    cyc('0, "load_decode");
    cyc('0, "load_exec");
    cyc(V_LD_MEM, "load_mem1");
    cyc(V_LD_MEM, "load_mem2");
    bus.mem_ack = 1'b1;
    cyc(V_LD_MEM, "load_mem3_ack");
    bus.mem_ack = 1'b0;
    cyc(V_RW | V_PC | f_wb(3'b011), "load_wb");

    // STORE never acked: fifteen MEM cycles, timeout on the last one.
    fetch(OP_STORE, "st_to_fetch");
    cyc('0, "st_to_decode");
    cyc('0, "st_to_exec");
    for (int i = 0; i < 14; i++) cyc(V_ST_MEM, "st_to_wait");
    cyc(V_ST_MEM | V_BE | V_PC, "st_to_timeout");

    // STORE acked immediately: back to FETCH after 3 + 1 cycles.
    fetch(OP_STORE, "st_ack_fetch");
    cyc('0, "st_ack_decode");
    cyc('0, "st_ack_exec");
    bus.mem_ack = 1'b1;
    cyc(V_ST_MEM | V_PC, "st_ack_mem");
    bus.mem_ack = 1'b0;

    // Illegal opcode and NOP.
    fetch(6'b101010, "ill_fetch");
    cyc(V_ILL | V_PC, "ill_decode");
    fetch(OP_NOP, "nop_fetch");
    cyc(V_PC, "nop_decode");

    // Reset mid-MEM after carry was set: abort, re-clear, carry cleared.
    fetch(OP_ADD, "add3_fetch");
    cyc('0, "add3_decode");
    bus.alu_carry_out = 1'b1;
    cyc(v_exec(4'b0001, 1'b0), "add3_exec");
    bus.alu_carry_out = 1'b0;
    cyc(V_ALU_WB, "add3_wb");
    fetch(OP_LOAD, "rst_ld_fetch");
    cyc('0, "rst_ld_decode");
    cyc('0, "rst_ld_exec");
    cyc(V_LD_MEM, "rst_ld_mem1");
    rst = 1'b1;
    bus.mem_ack = 1'b1;
    cyc(V_LD_MEM, "rst_ld_mem2");
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) cyc(V_RR, "rst_reinit");
    fetch(OP_ADC, "adc_rst_fetch");
    cyc('0, "adc_rst_decode");
    cyc(v_exec(4'b0110, 1'b0), "adc_rst_exec");
    cyc(V_ALU_WB, "adc_rst_wb");

    // HLT: halted held while instr_valid toggles.
    fetch(OP_HLT, "hlt_fetch");
    cyc('0, "hlt_decode");
    for (int i = 0; i < 4; i++) begin
      bus.instr_valid = (i % 2 == 0);
      bus.opcode      = OP_ADD;
      cyc(V_H, "halt_hold");
    end
    bus.instr_valid = 1'b0;

    checks++;
    if (bus.state_dbg !== ST_HALT) begin
      failures++;
      $display("FAIL halt_state: got=%0d expected=%0d", bus.state_dbg, ST_HALT);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
